rx_frame_ctrl: RTL

Receive-side frame controller that sits directly behind the UART receiver. It consumes bytes from `rcv_block` (`rx_data`, `data_ready`, `overrun_error`, `framing_error`) and acknowledges each one with `data_read`. It assembles `SYNC | CMD | LEN | PAYLOAD[LEN] | CHK` frames into a command/payload register set, then holds a validated frame for the cracker core with a valid/ack handshake. It also reports line, length, checksum and (optionally) timeout errors.

---
 rtl/rx_frame_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_ctrl.sv
// Receive framer: assembles SYNC|CMD|LEN|PAYLOAD|CHK from the UART receiver and holds it until acked; registered outputs, at most one byte per 2 cycles.
// No bytes are acknowledged while a frame is held; RX_TIMEOUT_EN adds an inter-byte timeout (err 00).
module rx_frame_ctrl #(
   parameter int         MAX_LEN     = 16,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [7:0]           rx_data_i,
   input  logic                 data_ready_i,
   input  logic                 overrun_error_i,
   input  logic                 framing_error_i,
   output logic                 data_read_o,
   output logic [7:0]           cmd_out_o,
   output logic [5:0]           len_out_o,
   output logic [8*MAX_LEN-1:0] payload_out_o,
   output logic                 frame_valid_o,
   input  logic                 frame_ack_i,
   output logic                 err_pulse_o,
   output logic [1:0]           err_code_o
);

   typedef enum logic [2:0] {
      ST_HUNT, ST_CMD, ST_LEN, ST_PAY, ST_CHK, ST_HOLD
   } state_e;

   typedef struct packed {
      logic [7:0] cmd;
      logic [5:0] len;
   } hdr_t;

   localparam logic [1:0] ERR_TMO  = 2'b00;
   localparam logic [1:0] ERR_LINE = 2'b01;
   localparam logic [1:0] ERR_LEN  = 2'b10;
   localparam logic [1:0] ERR_CHK  = 2'b11;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_e     state_q, state_d;
   hdr_t       hdr_q, hdr_d;
   logic       data_read_q, data_read_d;
   logic       frame_valid_q, frame_valid_d;
   logic       err_pulse_q, err_pulse_d;
   logic [1:0] err_code_q, err_code_d;
   logic [7:0] chk_q, chk_d;
   logic [5:0] idx_q, idx_d;
   logic [7:0] payload_q [MAX_LEN];
   logic [7:0] payload_d [MAX_LEN];

   logic       accept;
   logic       line_err;
   logic       tmo_hit;
   logic [5:0] idx_inc;

   // data_read_q blocks a second accept while the receiver clears data_ready
   assign accept   = (state_q != ST_HOLD) && data_ready_i && !data_read_q;
   assign line_err = overrun_error_i | framing_error_i;
   assign idx_inc  = idx_q + 6'd1;

`ifdef RX_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          in_frame;

   assign in_frame = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                     (state_q == ST_PAY) || (state_q == ST_CHK);
   assign tmo_hit  = in_frame && !accept && (tmo_q == TMO_LAST);

   always_comb begin
      tmo_d = '0;
      if (in_frame && !accept && !tmo_hit) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HUNT: begin
            if (accept && !line_err && rx_data_i == SYNC_BYTE) begin
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            if (accept) begin
               state_d = line_err ? ST_HUNT : ST_LEN;
            end
         end
         ST_LEN: begin
            if (accept) begin
               if (line_err || rx_data_i > MAX_LEN_B) begin
                  state_d = ST_HUNT;
               end else if (rx_data_i == 8'd0) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_PAY;
               end
            end
         end
         ST_PAY: begin
            if (accept) begin
               if (line_err) begin
                  state_d = ST_HUNT;
               end else if (idx_inc == hdr_q.len) begin
                  state_d = ST_CHK;
               end
            end
         end
         ST_CHK: begin
            if (accept) begin
               state_d = (!line_err && rx_data_i == chk_q) ? ST_HOLD : ST_HUNT;
            end
         end
         ST_HOLD: begin
            if (frame_ack_i) begin
               state_d = ST_HUNT;
            end
         end
         default: state_d = ST_HUNT;
      endcase
      if (tmo_hit) begin
         state_d = ST_HUNT;
      end
   end

   always_comb begin
      data_read_d   = accept;
      frame_valid_d = (state_d == ST_HOLD);
      err_pulse_d   = 1'b0;
      err_code_d    = err_code_q;
      hdr_d         = hdr_q;
      chk_d         = chk_q;
      idx_d         = idx_q;
      payload_d     = payload_q;
      if (accept && line_err) begin
         err_pulse_d = 1'b1;
         err_code_d  = ERR_LINE;
      end else if (accept) begin
         case (state_q)
            ST_HUNT: begin
               // Clear payload on the way into CMD so short frames never expose stale bytes
               if (rx_data_i == SYNC_BYTE) begin
                  for (int i = 0; i < MAX_LEN; i++) begin
                     payload_d[i] = 8'd0;
                  end
               end
            end
            ST_CMD: begin
               hdr_d.cmd = rx_data_i;
               chk_d     = rx_data_i;
            end
            ST_LEN: begin
               chk_d = chk_q ^ rx_data_i;
               if (rx_data_i > MAX_LEN_B) begin
                  err_pulse_d = 1'b1;
                  err_code_d  = ERR_LEN;
               end else begin
                  hdr_d.len = rx_data_i[5:0];
                  idx_d     = 6'd0;
               end
            end
            ST_PAY: begin
               for (int i = 0; i < MAX_LEN; i++) begin
                  if (idx_q == 6'(i)) begin
                     payload_d[i] = rx_data_i;
                  end
               end
               chk_d = chk_q ^ rx_data_i;
               idx_d = idx_inc;
            end
            ST_CHK: begin
               if (rx_data_i != chk_q) begin
                  err_pulse_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end
            end
            default: ;
         endcase
      end else if (tmo_hit) begin
         err_pulse_d = 1'b1;
         err_code_d  = ERR_TMO;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_read_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         err_pulse_q   <= 1'b0;
         err_code_q    <= ERR_TMO;
         hdr_q         <= '0;
         chk_q         <= 8'd0;
         idx_q         <= 6'd0;
         payload_q     <= '{default: 8'd0};
      end else begin
         data_read_q   <= data_read_d;
         frame_valid_q <= frame_valid_d;
         err_pulse_q   <= err_pulse_d;
         err_code_q    <= err_code_d;
         hdr_q         <= hdr_d;
         chk_q         <= chk_d;
         idx_q         <= idx_d;
         payload_q     <= payload_d;
      end
   end

   assign data_read_o   = data_read_q;
   assign frame_valid_o = frame_valid_q;
   assign err_pulse_o   = err_pulse_q;
   assign err_code_o    = err_code_q;
   assign cmd_out_o     = hdr_q.cmd;
   assign len_out_o     = hdr_q.len;

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_pay
      assign payload_out_o[8*g +: 8] = payload_q[g];
   end

endmodule
